// File: rtl/ahb_xip_cache_ctrl.sv
// AHB-Lite read front-end for the QSPI XiP line cache. Reads hit or fetch a 16-byte line; writes get a 2-cycle ERROR.
// Ports: AHB slave (HSEL..HRESP), cache lookup/fill (c_*), line reader (fr_*). Option: XIP_PERF_CNT_EN adds hit_cnt/miss_cnt.
module ahb_xip_cache_ctrl #(
  parameter int LINE_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [23:0] c_addr,
  input  logic        c_hit,
  input  logic [31:0] c_do,
  output logic        c_wr,
  output logic        fr_rd,
  output logic [23:0] fr_addr,
  input  logic        fr_done
`ifdef XIP_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OB = $clog2(LINE_SIZE);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RESP, ERR1, ERR2
  } state_t;

  state_t      state;
  logic [23:0] addr_q;
  logic        wr_q;
  logic        pend;
  logic        accept;
  logic        err_go;
  logic        rd_hit;
  logic        rd_miss;
  logic        unused;

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign err_go  = pend & wr_q;
  assign rd_hit  = pend & ~wr_q & c_hit;
  assign rd_miss = pend & ~wr_q & ~c_hit;
  assign unused  = ^{HADDR[31:24], HSIZE, HTRANS[0]};

  assign c_addr  = addr_q;
  assign fr_addr = {addr_q[23:OB], {OB{1'b0}}};
  assign HRDATA  = c_do;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      pend   <= 1'b0;
    end else if (accept) begin
      addr_q <= HADDR[23:0];
      wr_q   <= HWRITE;
      pend   <= 1'b1;
    end else if (HREADY) begin
      pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            err_go:  state <= ERR2;
            rd_miss: state <= REQ;
            default: state <= IDLE;
          endcase
        end
        REQ:  state <= WAIT;
        WAIT: if (fr_done) state <= RESP;
        RESP: state <= IDLE;
        ERR1: state <= ERR2;
        ERR2: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Hit/miss must be resolved in the same IDLE cycle,
  // so the bus outputs decode state plus c_hit.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    fr_rd     = 1'b0;
    c_wr      = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          err_go: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
          end
          rd_miss: HREADYOUT = 1'b0;
          default: HREADYOUT = 1'b1;
        endcase
      end
      REQ: begin
        fr_rd     = 1'b1;
        HREADYOUT = 1'b0;
      end
      WAIT: begin
        HREADYOUT = 1'b0;
        c_wr      = fr_done;
      end
      RESP: HREADYOUT = 1'b1;
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: HRESP = 1'b1;
      default: HREADYOUT = 1'b1;
    endcase
  end

`ifdef XIP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && rd_hit)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && rd_miss)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_xip_cache_ctrl.sv
// Bench for ahb_xip_cache_ctrl: cache + line reader environment models,
// vector table, hand sequences and randomized reads against a line-residency model.
module tb_ahb_xip_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [23:0] c_addr;
  logic        c_hit;
  logic [31:0] c_do;
  logic        c_wr;
  logic        fr_rd;
  logic [23:0] fr_addr;
  logic        fr_done = 1'b0;
`ifdef XIP_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  ahb_xip_cache_ctrl #(.LINE_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .c_addr(c_addr), .c_hit(c_hit), .c_do(c_do), .c_wr(c_wr),
    .fr_rd(fr_rd), .fr_addr(fr_addr), .fr_done(fr_done)
`ifdef XIP_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  function automatic logic [31:0] flash(input logic [23:0] a);
    return (32'(a) * 32'h0001_0003) ^ 32'hA5C3_0F1E;
  endfunction

  // external direct-mapped cache: 16 lines x 4 words
  logic        vld_m [16] = '{default: 1'b0};
  logic [15:0] tag_m [16] = '{default: 16'h0};
  logic [31:0] dat_m [16][4] = '{default: '{default: 32'hDEAD_BEEF}};

  assign c_hit = vld_m[c_addr[7:4]] && tag_m[c_addr[7:4]] == c_addr[23:8];
  assign c_do  = dat_m[c_addr[7:4]][c_addr[3:2]];

  int n_frrd = 0;
  int n_cwr = 0;
  int cwr_bad = 0;

  always @(posedge clk) begin
    if (fr_rd) n_frrd <= n_frrd + 1;
    if (c_wr) begin
      n_cwr <= n_cwr + 1;
      vld_m[c_addr[7:4]] <= 1'b1;
      tag_m[c_addr[7:4]] <= c_addr[23:8];
      for (int k = 0; k < 4; k++)
        dat_m[c_addr[7:4]][k] <=
          flash({c_addr[23:4], 4'h0} + 24'(4 * k));
    end
    if (c_wr && !fr_done) cwr_bad <= cwr_bad + 1;
  end

  // line reader: fr_done fr_delay cycles after fr_rd, aborted by reset
  int fr_delay = 40;
  bit rd_abort;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n && fr_rd) begin
        rd_abort = 1'b0;
        for (int i = 0; i < fr_delay; i++) begin
          @(posedge clk); #1;
          if (!rst_n) begin
            rd_abort = 1'b1;
            break;
          end
        end
        if (!rd_abort) begin
          fr_done = 1'b1;
          @(posedge clk); #1;
          fr_done = 1'b0;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: which line address occupies each set
  int line_at [16];
  int exp_hit = 0;
  int exp_miss = 0;

  function automatic bit model_hit(input logic [23:0] a);
    int la;
    la = int'(a) / 16;
    return line_at[la % 16] == la;
  endfunction

  function automatic void model_fill(input logic [23:0] a);
    int la;
    la = int'(a) / 16;
    line_at[la % 16] = la;
  endfunction

  // called at posedge+1 with HREADY high
  task automatic xfer(input logic [23:0] a, input logic w,
                      output int ws, output logic [31:0] d,
                      output logic r0, output logic r1);
    HSEL = 1'b1; HTRANS = 2'b10;
    HADDR = {8'h00, a}; HWRITE = w;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    ws = 0;
    @(negedge clk);
    r0 = HRESP;
    while (HREADYOUT !== 1'b1 && ws < 200) begin
      ws++;
      @(negedge clk);
    end
    d = HRDATA;
    r1 = HRESP;
    @(posedge clk); #1;
  endtask

  task automatic check_xfer(input string nm, input logic [23:0] a,
                            input logic w, input int dly,
                            input int ews, input logic eresp,
                            input int enfr);
    int ws, f0, w0;
    logic [31:0] d;
    logic r0, r1;
    fr_delay = dly;
    f0 = n_frrd;
    w0 = n_cwr;
    xfer(a, w, ws, d, r0, r1);
    chk({nm, " waits"}, ws, ews);
    chk({nm, " resp1"}, r0, eresp);
    chk({nm, " resp"}, r1, eresp);
    if (!w) chk({nm, " data"}, d, flash({a[23:2], 2'b00}));
    chk({nm, " fr_rd"}, n_frrd - f0, enfr);
    chk({nm, " c_wr"}, n_cwr - w0, enfr);
    if (enfr != 0)
      chk({nm, " fr_addr"}, fr_addr, {a[23:4], 4'h0});
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    int          dly;
    int          ws;
    logic        resp;
    int          nfr;
  } vec_t;

  vec_t tv [5];
  logic [23:0] ra;
  logic        rw;
  int          rd;
  int          f0, w0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) line_at[i] = -1;
    tv[0] = '{24'h000104, 1'b0, 40, 42, 1'b0, 1};
    tv[1] = '{24'h000108, 1'b0, 40, 0, 1'b0, 0};
    tv[2] = '{24'h000000, 1'b1, 40, 1, 1'b1, 0};
    tv[3] = '{24'h00010C, 1'b0, 40, 0, 1'b0, 0};
    tv[4] = '{24'h000114, 1'b0, 3, 5, 1'b0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst HREADYOUT", HREADYOUT, 1'b1);
    chk("rst HRESP", HRESP, 1'b0);
    chk("rst fr_rd", fr_rd, 1'b0);
    chk("rst c_wr", c_wr, 1'b0);
    chk("rst fr_addr", fr_addr, 24'h0);
    chk("rst c_addr", c_addr, 24'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      check_xfer($sformatf("tv%0d", i), tv[i].addr, tv[i].wr,
                 tv[i].dly, tv[i].ws, tv[i].resp, tv[i].nfr);
      if (!tv[i].wr) begin
        if (tv[i].nfr != 0) begin
          model_fill(tv[i].addr);
          exp_miss++;
        end else begin
          exp_hit++;
        end
      end
    end

    // back-to-back hits, one per cycle
    f0 = n_frrd;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h100;
    @(posedge clk); #1;
    HTRANS = 2'b11; HADDR = 32'h104;
    @(negedge clk);
    chk("b2b0 rdy", HREADYOUT, 1'b1);
    chk("b2b0 data", HRDATA, flash(24'h100));
    @(posedge clk); #1;
    HADDR = 32'h10C;
    @(negedge clk);
    chk("b2b1 rdy", HREADYOUT, 1'b1);
    chk("b2b1 data", HRDATA, flash(24'h104));
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge clk);
    chk("b2b2 rdy", HREADYOUT, 1'b1);
    chk("b2b2 data", HRDATA, flash(24'h10C));
    chk("b2b fr_rd", n_frrd - f0, 0);
    @(posedge clk); #1;
    exp_hit += 3;

`ifdef XIP_PERF_CNT_EN
    chk("perf hit", hit_cnt, 32'(exp_hit));
    chk("perf miss", miss_cnt, 32'(exp_miss));
`endif

    // reset in the middle of a fetch
    fr_delay = 20;
    f0 = n_frrd;
    w0 = n_cwr;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h200;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    for (int k = 0; k < 10 && n_frrd == f0; k++) begin
      @(posedge clk); #1;
    end
    chk("mid fr_rd", n_frrd - f0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid stall", HREADYOUT, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid rst HREADYOUT", HREADYOUT, 1'b1);
    chk("mid rst HRESP", HRESP, 1'b0);
    chk("mid rst fr_rd", fr_rd, 1'b0);
    chk("mid rst c_wr", c_wr, 1'b0);
    chk("mid rst fr_addr", fr_addr, 24'h0);
    chk("mid rst c_addr", c_addr, 24'h0);
`ifdef XIP_PERF_CNT_EN
    chk("mid rst hit_cnt", hit_cnt, 32'h0);
    chk("mid rst miss_cnt", miss_cnt, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    repeat (25) @(posedge clk);
    #1;
    chk("mid no c_wr", n_cwr - w0, 0);
    check_xfer("post", 24'h000200, 1'b0, 5, 7, 1'b0, 1);
    model_fill(24'h000200);
    exp_miss++;

    // randomized reads/writes against residency model
    for (int i = 0; i < 60; i++) begin
      ra = 24'($urandom_range(0, 1023)) & 24'hFFFFFC;
      if ($urandom_range(0, 3) == 0) ra[23:20] = 4'($urandom);
      rw = ($urandom_range(0, 7) == 0);
      rd = $urandom_range(1, 8);
      if (rw) begin
        check_xfer($sformatf("rnd%0d wr", i), ra, 1'b1, rd,
                   1, 1'b1, 0);
      end else if (model_hit(ra)) begin
        check_xfer($sformatf("rnd%0d hit", i), ra, 1'b0, rd,
                   0, 1'b0, 0);
        exp_hit++;
      end else begin
        check_xfer($sformatf("rnd%0d miss", i), ra, 1'b0, rd,
                   2 + rd, 1'b0, 1);
        model_fill(ra);
        exp_miss++;
      end
    end

    chk("c_wr only with fr_done", cwr_bad, 0);
`ifdef XIP_PERF_CNT_EN
    chk("perf hit end", hit_cnt, 32'(exp_hit));
    chk("perf miss end", miss_cnt, 32'(exp_miss));
`endif
    $display("[TB] model: %0d hits %0d misses since reset",
             exp_hit, exp_miss);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_xip_cache_ctrl.md
# ahb_xip_cache_ctrl

AHB-Lite slave front-end of the quad-SPI XiP subsystem. It accepts read transfers from the bus, performs a lookup in the direct-mapped line cache, and on a miss launches a 16-byte line fetch through the QSPI line reader, writes the returned line into the cache, and completes the stalled transfer. Write transfers are rejected with an AHB ERROR response.

## Interface
Parameters:
- `LINE_SIZE`, 16: cache line size in bytes. Only 16 is supported.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `HSEL`  in  1  slave select
- `HADDR`  in  32  address; only [23:0] used
- `HTRANS`  in  2  transfer type; bit 1 set means NONSEQ/SEQ
- `HWRITE`  in  1  write transfer
- `HSIZE`  in  3  ignored; full word always returned
- `HREADY`  in  1  bus-wide ready
- `HREADYOUT`  out  1  slave ready
- `HRDATA`  out  32  read data
- `HRESP`  out  1  0 = OKAY, 1 = ERROR
- `c_addr`  out  24  cache lookup/write address (drives both the data-select and hit-check address)
- `c_hit`  in  1  cache hit for `c_addr`
- `c_do`  in  32  cache word for `c_addr`
- `c_wr`  out  1  cache line write strobe
- `fr_rd`  out  1  line-fetch request, 1-cycle pulse
- `fr_addr`  out  24  line-aligned fetch address
- `fr_done`  in  1  fetch complete, 1-cycle pulse, line valid in that cycle

## Operation
- Address phase accepted when `HSEL & HTRANS[1] & HREADY`. On acceptance: `addr_q <= HADDR[23:0]`, `wr_q <= HWRITE`, `pend <= 1`. When not accepted but `HREADY=1`: `pend <= 0`.
- `c_addr = addr_q`. `fr_addr = {addr_q[23:4], 4'h0}`. `HRDATA = c_do` in all states.
- FSM states: IDLE, REQ, WAIT, RESP, ERR1, ERR2.
- IDLE:
  - If `pend=0`: `HREADYOUT=1`.
  - If `pend & wr_q`: `HREADYOUT=0`, `HRESP=1`, go to ERR2. Entering IDLE with this condition is itself the first error cycle, so ERR1 is an alias of that IDLE cycle.
  - If `pend & ~wr_q & c_hit`: `HREADYOUT=1`; zero-wait completion.
  - If `pend & ~wr_q & ~c_hit`: `HREADYOUT=0`, go to REQ.
- REQ: `fr_rd=1`, `HREADYOUT=0`, go to WAIT.
- WAIT: `HREADYOUT=0`.
  - `c_wr = fr_done`, combinational, so the line is written to index `addr_q[7:4]` with the tag from `addr_q`.
  - On `fr_done`, go to RESP.
- RESP: `HREADYOUT=1`, `HRDATA = c_do` (now a hit), go to IDLE. A new address phase may be accepted in this cycle.
- ERR2: `HREADYOUT=1`, `HRESP=1`, go to IDLE. `pend` clears unless a new phase is accepted.
- `fr_done` outside WAIT is ignored: no `c_wr`, no state change.

## Timing
- Reset values: state = IDLE, `pend=0`, `addr_q=0`, `wr_q=0`. Therefore `HREADYOUT=1`, `HRESP=0`, `fr_rd=0`, `c_wr=0`, `fr_addr=0`, `c_addr=0`.
- Hit: data returned in the first data-phase cycle (0 wait states).
- Miss: wait states = 2 + N, where N is the number of WAIT cycles up to and including the `fr_done` cycle. Data is valid in RESP.
- Write: exactly 2-cycle ERROR response (`HREADYOUT` 0 then 1, `HRESP=1` in both cycles).
- Back-to-back hits: one transfer per cycle.
- A miss followed by a pipelined address phase: the second address is sampled only in the RESP cycle, because `HREADY` is low until then.
- Reset asserted mid-fetch: immediate return to reset values and `fr_rd` drops. The line reader is reset by the same `rst_n`. No partial `c_wr` occurs.
- `c_hit` is evaluated combinationally each IDLE cycle. `addr_q` is stable throughout the data phase.

## Configuration
- `XIP_PERF_CNT_EN`: when defined, adds two outputs, `hit_cnt` and `miss_cnt` (each 32 bits, reset to 0, wrap on overflow).
  - `hit_cnt` increments on each IDLE cycle with `pend & ~wr_q & c_hit`.
  - `miss_cnt` increments on each IDLE to REQ transition.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

## Test plan
- Cold read at 0x000104 with the line reader model returning `fr_done` 40 cycles after `fr_rd`:
  - `fr_rd` pulses once with `fr_addr=0x000100`.
  - `c_wr` is high only in the `fr_done` cycle.
  - `HREADYOUT` is low for 42 cycles, then data = word 1 of the line with `HRESP=0`.
- Re-read 0x000108 after the previous test → hit, `HREADYOUT=1` in the first data cycle, word 2 returned, no `fr_rd`.
- Write to 0x000000 → `HRESP=1` for two cycles with `HREADYOUT` 0 then 1; no `fr_rd`, no `c_wr`.
- Back-to-back NONSEQ reads 0x100, 0x104, 0x10C, all hits → three transfers in three consecutive cycles, zero wait states.
- `rst_n` pulsed low during WAIT, then a read to 0x000200 → outputs return to reset values, `fr_rd` issued fresh with `fr_addr=0x000200`, and the transfer completes normally.
- With `XIP_PERF_CNT_EN`: one miss plus three hits → `miss_cnt=1`, `hit_cnt=3`.
